// File: rtl/i10507_pkg.sv
// Shared types, default trigger constants and the output Boolean function for the i10507 trigger core.
// Output function f is evaluated combinationally on the registered input vector.
package i10507_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FIRE  = 2'd2
   } state_e;

   localparam logic [7:0] TRIG_A_DEF         = 8'hA5;
   localparam logic [7:0] TRIG_B_DEF         = 8'h5A;
   localparam logic [7:0] PAYLOAD_CYCLES_DEF = 8'd4;

   // Bit 7 is N0, bit 0 is N7.
   function automatic logic f_out(input logic [7:0] x);
      return (x[7] & x[6]) ^ (x[5] | x[4]) ^ (x[3] & ~x[2]) ^ (x[1] ^ x[0]);
   endfunction

endpackage

// File: rtl/i10507_trigger_fsm.sv
// Sequence detector: TRIG_A then TRIG_B on consecutive edges raises fire for PAYLOAD_CYCLES cycles.
// fire is registered; inputs are ignored while firing, and reset cancels the payload asynchronously.
module i10507_trigger_fsm
   import i10507_pkg::*;
#(
   parameter logic [7:0] TRIG_A         = TRIG_A_DEF,
   parameter logic [7:0] TRIG_B         = TRIG_B_DEF,
   parameter logic [7:0] PAYLOAD_CYCLES = PAYLOAD_CYCLES_DEF
) (
   input  logic       CK,
   input  logic       reset,
   input  logic [7:0] V,
   output logic       fire
);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;

   always_ff @(posedge CK or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (V == TRIG_A) state_d = ARMED;
         end
         ARMED: begin
            // TRIG_B wins so that TRIG_A==TRIG_B still fires on A,A.
            if (V == TRIG_B) begin
               state_d = FIRE;
               cnt_d   = PAYLOAD_CYCLES - 8'd1;
            end else if (V != TRIG_A) begin
               state_d = IDLE;
            end
         end
         FIRE: begin
            if (cnt_q == 8'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 8'd1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign fire = (state_q == FIRE);

endmodule

// File: rtl/i10507_trigger_core.sv
// Registers {N0..N7} and drives f(in_q), inverted while the trigger payload is active.
// One-edge latency from inputs to out; out depends only on flops.
module i10507_trigger_core
   import i10507_pkg::*;
#(
   parameter logic [7:0] TRIG_A         = TRIG_A_DEF,
   parameter logic [7:0] TRIG_B         = TRIG_B_DEF,
   parameter logic [7:0] PAYLOAD_CYCLES = PAYLOAD_CYCLES_DEF
) (
   input  logic N0,
   input  logic N1,
   input  logic N2,
   input  logic N3,
   input  logic N4,
   input  logic N5,
   input  logic N6,
   input  logic N7,
   input  logic CK,
   input  logic reset,
   output logic out
);

   logic [7:0] in_d, in_q;
   logic       fire;

   assign in_d = {N0, N1, N2, N3, N4, N5, N6, N7};

   always_ff @(posedge CK or posedge reset) begin
      if (reset) in_q <= 8'd0;
      else       in_q <= in_d;
   end

   // The FSM sees the live vector so its state lines up with in_q on the same edge.
   i10507_trigger_fsm #(
      .TRIG_A         (TRIG_A),
      .TRIG_B         (TRIG_B),
      .PAYLOAD_CYCLES (PAYLOAD_CYCLES)
   ) u_fsm (
      .CK    (CK),
      .reset (reset),
      .V     (in_d),
      .fire  (fire)
   );

   assign out = f_out(in_q) ^ fire;

endmodule

// File: tb/tb_i10507_trigger_core.sv
// Randomized and directed bench for i10507_trigger_core against a remaining-cycles payload model.
module tb_i10507_trigger_core;

   localparam logic [7:0] TA = 8'hA5;
   localparam logic [7:0] TB = 8'h5A;
   localparam int         PC = 4;

   logic       CK = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] vdrv = 8'hFF;
   logic       out;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: last sampled vector, whether that vector could start a sequence,
   // and how many inverted output cycles remain (including the current one).
   logic [7:0] m_last = 8'd0;
   bit         m_prev_a = 1'b0;
   int         m_fire_left = 0;

   i10507_trigger_core dut (
      .N0    (vdrv[7]),
      .N1    (vdrv[6]),
      .N2    (vdrv[5]),
      .N3    (vdrv[4]),
      .N4    (vdrv[3]),
      .N5    (vdrv[2]),
      .N6    (vdrv[1]),
      .N7    (vdrv[0]),
      .CK    (CK),
      .reset (reset),
      .out   (out)
   );

   always #5 CK = ~CK;

   function automatic bit ref_f(input logic [7:0] v);
      bit n0, n1, n2, n3, n4, n5, n6, n7;
      {n0, n1, n2, n3, n4, n5, n6, n7} = v;
      return (n0 && n1) ^ (n2 || n3) ^ (n4 && !n5) ^ (n6 ^ n7);
   endfunction

   function automatic bit model_out();
      return ref_f(m_last) ^ (m_fire_left > 0);
   endfunction

   always @(posedge CK or posedge reset) begin
      if (reset) begin
         m_last      = 8'd0;
         m_prev_a    = 1'b0;
         m_fire_left = 0;
      end else begin
         m_last = vdrv;
         if (m_fire_left > 0) begin
            m_fire_left = m_fire_left - 1;
            m_prev_a    = 1'b0;
         end else if (m_prev_a && vdrv == TB) begin
            m_fire_left = PC;
            m_prev_a    = 1'b0;
         end else begin
            m_prev_a = (vdrv == TA);
         end
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: out=%0b expected=%0b at %0t", name, act, exp, $time);
      end
   endtask

   // Continuous comparison against the model, away from the active edge.
   always @(negedge CK) begin
      check("model", out, model_out());
   end

   // Drive v before an edge; optionally pin the post-edge output to a hand value.
   task automatic step(input logic [7:0] v, input int lit, input string name);
      @(negedge CK);
      #1 vdrv = v;
      @(posedge CK);
      #1;
      if (lit >= 0) check(name, out, lit[0]);
   endtask

   initial begin
      reset = 1'b1;
      vdrv  = 8'hFF;
      repeat (3) @(posedge CK);
      #1 check("reset_ff", out, 1'b0);
      @(negedge CK);
      reset = 1'b0;

      step(8'hC0, 1, "c0");
      step(8'h00, 0, "tt_00");
      step(8'h20, 1, "tt_20");
      step(8'h30, 1, "tt_30");
      step(8'h02, 1, "tt_02");
      step(8'h03, 0, "tt_03");
      step(8'h08, 1, "tt_08");
      step(8'h0C, 0, "tt_0c");
      step(8'hFF, 0, "tt_ff");

      step(8'hA5, 0, "trig_a5");
      step(8'h5A, 0, "trig_5a");
      step(8'h00, 1, "pay_1");
      step(8'h00, 1, "pay_2");
      step(8'h00, 1, "pay_3");
      step(8'h00, 0, "pay_end");

      step(8'hA5, 0, "brk_a5");
      step(8'h00, 0, "brk_00");
      step(8'h5A, 1, "brk_5a");

      step(8'hA5, 0, "aa_1");
      step(8'hA5, 0, "aa_2");
      step(8'h5A, 0, "aa_fire");
      step(8'h00, 1, "aa_pay");
      repeat (4) step(8'h00, -1, "");

      step(8'hA5, 0, "rst_a5");
      step(8'h5A, 0, "rst_5a");
      step(8'h00, 1, "rst_pay2");
      #2 reset = 1'b1;
      #1 check("rst_mid_fire", out, 1'b0);
      @(negedge CK);
      #1 reset = 1'b0;
      step(8'h00, 0, "rst_after");

      for (int v = 0; v < 256; v++) begin
         logic [7:0] vv;
         vv = v[7:0];
         step(vv, int'(ref_f(vv)), "sweep");
      end

      for (int i = 0; i < 600; i++) begin
         logic [7:0] rv;
         case ($urandom_range(0, 3))
            0:       rv = TA;
            1:       rv = TB;
            default: rv = 8'($urandom);
         endcase
         step(rv, -1, "");
      end

      @(negedge CK);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
